pipeline_run_ctrl: RTL and testbench
====================================

# pipeline_run_ctrl

Run/step/dump sequencer for the MIPS pipeline. Owns the global pipeline enable that feeds `general_control.i_enable` and every stage-register enable. It takes RUN, STEP, HALT and DUMP commands from the debug front-end over a valid/ready handshake. It also sequences a register-file read-out for the debug link.

## Interface
Parameters:
- `NB_CMD`, 2, command code width.
- `REG_COUNT`, 32, number of register-file entries swept by DUMP.
- `NB_ADDR`, 5, dump address width; `2**NB_ADDR >= REG_COUNT`.
- `NB_CYCLES`, 32, cycle-counter width.

Ports (clock and reset first):
- `i_clk`  in  1  single system clock; all logic on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_cmd_valid`  in  1  command present.
- `i_cmd`  in  NB_CMD  command: 0 RUN, 1 STEP, 2 HALT, 3 DUMP.
- `o_cmd_ready`  out  1  command accepted when valid and ready are both high on an edge.
- `i_halt_detected`  in  1  HALT instruction retired in WB this cycle.
- `o_enable`  out  1  pipeline enable.
- `o_halted`  out  1  program finished (state DONE).
- `o_dump_valid`  out  1  `o_dump_addr` is valid for a register read.
- `o_dump_addr`  out  NB_ADDR  register index being dumped.
- `i_dump_ready`  in  1  consumer took the current address.
- `o_cycle_count`  out  NB_CYCLES  enabled cycles since reset.

## Operation
States: IDLE, RUN, STEP, DUMP, DONE. State is registered, and all outputs are Moore decodes of state and registers.
- Reset values: state IDLE, `o_enable`=0, `o_halted`=0, `o_cmd_ready`=1, `o_dump_valid`=0, `o_dump_addr`=0, `o_cycle_count`=0, return-state register = IDLE.
- `o_cmd_ready`=1 in IDLE, RUN and DONE; 0 in STEP and DUMP.
- IDLE:
  - RUN → RUN.
  - STEP → STEP.
  - DUMP → DUMP, with return-state = IDLE.
  - HALT is accepted and is a no-op.
- RUN:
  - `o_enable`=1.
  - `i_halt_detected` → DONE.
  - HALT command → IDLE.
  - RUN, STEP and DUMP commands are accepted and ignored.
  - If `i_halt_detected` and a HALT command occur in the same cycle, DONE wins.
- STEP:
  - `o_enable`=1 for exactly one cycle, then → IDLE.
  - If `i_halt_detected` occurs in that cycle → DONE.
- DUMP:
  - `o_enable`=0, `o_dump_valid`=1.
  - `o_dump_addr` increments on each edge where `i_dump_ready`=1.
  - On the handshake at address REG_COUNT-1: `o_dump_addr` returns to 0, `o_dump_valid` drops, and state → return-state.
  - `i_dump_ready` held low stalls the sweep indefinitely.
- DONE:
  - `o_halted`=1, `o_enable`=0.
  - DUMP → DUMP with return-state = DONE.
  - All other commands are accepted and ignored.
  - DONE is left only by `i_rst`.
- `i_halt_detected` is ignored outside RUN and STEP.
- `o_cycle_count` increments on every edge where `o_enable`=1 and saturates at all-ones; no wrap.
- `i_rst` mid-operation (RUN, STEP or a partial DUMP) returns everything to reset values on the next edge. No partial dump completion.

## Timing
- Command accepted at edge k → new state after edge k → `o_enable`=1 during cycle k+1.
  - RUN/STEP start latency: 1 cycle.
- STEP yields exactly one enabled cycle (k+1); IDLE from edge k+2.
- `i_halt_detected` high in cycle t → `o_enable`=0 from cycle t+1. The pipeline executes cycle t only.
- DUMP of REG_COUNT entries with `i_dump_ready` tied high: `o_dump_valid` for REG_COUNT cycles, return state on the following cycle.
- No combinational path from inputs to outputs.

## Structure
- Package `pipeline_ctrl_pkg`:
  - command codes: CMD_RUN, CMD_STEP, CMD_HALT, CMD_DUMP;
  - state encoding: ST_IDLE, ST_RUN, ST_STEP, ST_DUMP, ST_DONE.
- One sub-module, `dump_addr_seq`: address counter with valid/ready, last-entry detect and done pulse; parameterized by REG_COUNT/NB_ADDR.
- The saturating cycle counter stays inline.

## Test plan
- Reset, then RUN at edge 2; assert `i_halt_detected` in cycle 10 → `o_enable` high cycles 3–10, `o_halted`=1 from cycle 11, `o_cycle_count`=8.
- Three back-to-back STEPs (valid held high) → exactly 3 enabled cycles; `o_cmd_ready`=0 during each STEP cycle; `o_cycle_count`=3.
- RUN then HALT command in cycle 6 together with `i_halt_detected` → state DONE, `o_halted`=1; a later RUN is ignored and `o_enable` stays 0.
- DUMP from DONE with `i_dump_ready` toggling 1/0 → addresses 0..31 each emitted once in order, 63 valid cycles, returns to DONE with `o_halted`=1.
- `i_rst` during DUMP at address 17 → next cycle addr 0, valid 0, state IDLE, count 0.
- Force count to all-ones − 1 and RUN for 4 cycles → count holds at all-ones.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - command codes and sequencer states for pipeline_run_ctrl
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_RUN  = 2'd0,
        CMD_STEP = 2'd1,
        CMD_HALT = 2'd2,
        CMD_DUMP = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_DUMP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic is_enabled_state(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

    function automatic logic is_busy_state(input state_e s);
        return (s == ST_STEP) || (s == ST_DUMP);
    endfunction

endpackage

// File: rtl/dump_addr_seq.sv
// rtl/dump_addr_seq.sv - register-file sweep address counter with valid/ready and done pulse
module dump_addr_seq #(
    parameter int REG_COUNT = 32,
    parameter int NB_ADDR   = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [NB_ADDR-1:0] o_addr,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(REG_COUNT - 1);

    logic last;

    assign last   = (o_addr == LAST_ADDR);
    // Combinational so the owner can change state on the same edge as the final handshake.
    assign o_done = o_valid & i_ready & last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_addr  <= '0;
        end else if (i_start) begin
            o_valid <= 1'b1;
            o_addr  <= '0;
        end else if (o_valid && i_ready) begin
            if (last) begin
                o_valid <= 1'b0;
                o_addr  <= '0;
            end else begin
                o_addr <= o_addr + NB_ADDR'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// rtl/pipeline_run_ctrl.sv - run/step/halt/dump sequencer owning the global pipeline enable
module pipeline_run_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_CMD    = 2,
    parameter int REG_COUNT = 32,
    parameter int NB_ADDR   = 5,
    parameter int NB_CYCLES = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    input  logic [NB_CMD-1:0]    i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_halt_detected,
    output logic                 o_enable,
    output logic                 o_halted,
    output logic                 o_dump_valid,
    output logic [NB_ADDR-1:0]   o_dump_addr,
    input  logic                 i_dump_ready,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    state_e state;
    state_e next_state;
    state_e ret_state;
    cmd_e   cmd;
    logic   cmd_fire;
    logic   dump_start;
    logic   dump_done;

    assign cmd      = cmd_e'(i_cmd[1:0]);
    assign cmd_fire = i_cmd_valid & o_cmd_ready;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd)
                        CMD_RUN:  next_state = ST_RUN;
                        CMD_STEP: next_state = ST_STEP;
                        CMD_DUMP: next_state = ST_DUMP;
                        default:  next_state = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // A retiring HALT instruction outranks a HALT command in the same cycle.
                if (i_halt_detected) begin
                    next_state = ST_DONE;
                end else if (cmd_fire && cmd == CMD_HALT) begin
                    next_state = ST_IDLE;
                end
            end
            ST_STEP: next_state = i_halt_detected ? ST_DONE : ST_IDLE;
            ST_DUMP: begin
                if (dump_done) begin
                    next_state = ret_state;
                end
            end
            ST_DONE: begin
                if (cmd_fire && cmd == CMD_DUMP) begin
                    next_state = ST_DUMP;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign dump_start = (next_state == ST_DUMP) && (state != ST_DUMP);

    // Outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            ret_state   <= ST_IDLE;
            o_enable    <= 1'b0;
            o_halted    <= 1'b0;
            o_cmd_ready <= 1'b1;
        end else begin
            state       <= next_state;
            if (dump_start) begin
                ret_state <= (state == ST_DONE) ? ST_DONE : ST_IDLE;
            end
            o_enable    <= is_enabled_state(next_state);
            o_halted    <= (next_state == ST_DONE);
            o_cmd_ready <= !is_busy_state(next_state);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cycle_count <= '0;
        end else if (o_enable && (o_cycle_count != '1)) begin
            o_cycle_count <= o_cycle_count + NB_CYCLES'(1);
        end
    end

    dump_addr_seq #(
        .REG_COUNT (REG_COUNT),
        .NB_ADDR   (NB_ADDR)
    ) u_dump_addr_seq (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (dump_start),
        .i_ready (i_dump_ready),
        .o_valid (o_dump_valid),
        .o_addr  (o_dump_addr),
        .o_done  (dump_done)
    );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb/tb_pipeline_run_ctrl.sv - self-checking bench for pipeline_run_ctrl against a behavioural model
module tb_pipeline_run_ctrl;

    localparam int REG_COUNT = 32;
    localparam longint CNT_MAX   = 64'hFFFF_FFFF;
    localparam longint CNT_MAX_S = 7;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        halt_det;
    logic        dump_ready;

    logic        cmd_ready, enable, halted, dump_valid;
    logic [4:0]  dump_addr;
    logic [31:0] cycle_count;

    logic        s_cmd_ready, s_enable, s_halted, s_dump_valid;
    logic [4:0]  s_dump_addr;
    logic [2:0]  s_cycle_count;

    int n_checks;
    int n_errors;

    logic   m_run, m_step, m_dump, m_halt;
    int     m_idx;
    longint m_cnt, m_cnt_s;

    pipeline_run_ctrl #(
        .NB_CMD(2), .REG_COUNT(REG_COUNT), .NB_ADDR(5), .NB_CYCLES(32)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(cmd_ready), .i_halt_detected(halt_det), .o_enable(enable),
        .o_halted(halted), .o_dump_valid(dump_valid), .o_dump_addr(dump_addr),
        .i_dump_ready(dump_ready), .o_cycle_count(cycle_count)
    );

    pipeline_run_ctrl #(
        .NB_CMD(2), .REG_COUNT(REG_COUNT), .NB_ADDR(5), .NB_CYCLES(3)
    ) dut_small (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(s_cmd_ready), .i_halt_detected(halt_det), .o_enable(s_enable),
        .o_halted(s_halted), .o_dump_valid(s_dump_valid), .o_dump_addr(s_dump_addr),
        .i_dump_ready(dump_ready), .o_cycle_count(s_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Model: one cycle of the debug sequencer described as flags, not states.
    task automatic model_step();
        if (rst) begin
            m_run = 0; m_step = 0; m_dump = 0; m_halt = 0;
            m_idx = 0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            if (m_run || m_step) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (m_cnt_s < CNT_MAX_S) m_cnt_s++;
            end
            if (m_dump) begin
                if (dump_ready) begin
                    if (m_idx == REG_COUNT - 1) begin
                        m_dump = 0;
                        m_idx  = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (m_step) begin
                m_step = 0;
                if (halt_det) m_halt = 1;
            end else if (m_run) begin
                if (halt_det) begin
                    m_run  = 0;
                    m_halt = 1;
                end else if (cmd_valid && cmd == 2'd2) begin
                    m_run = 0;
                end
            end else if (cmd_valid) begin
                if (cmd == 2'd3) m_dump = 1;
                else if (!m_halt && cmd == 2'd0) m_run = 1;
                else if (!m_halt && cmd == 2'd1) m_step = 1;
            end
        end
    endtask

    task automatic check_all();
        check("enable",     64'(enable),      64'(m_run || m_step));
        check("cmd_ready",  64'(cmd_ready),   64'(!(m_step || m_dump)));
        check("halted",     64'(halted),      64'(m_halt && !m_dump));
        check("dump_valid", 64'(dump_valid),  64'(m_dump));
        check("dump_addr",  64'(dump_addr),   64'(m_idx));
        check("count",      64'(cycle_count), 64'(m_cnt));
        check("s_enable",   64'(s_enable),    64'(m_run || m_step));
        check("s_ready",    64'(s_cmd_ready), 64'(!(m_step || m_dump)));
        check("s_halted",   64'(s_halted),    64'(m_halt && !m_dump));
        check("s_dvalid",   64'(s_dump_valid), 64'(m_dump));
        check("s_daddr",    64'(s_dump_addr), 64'(m_idx));
        check("s_count",    64'(s_cycle_count), 64'(m_cnt_s));
    endtask

    task automatic cycle(input logic v, input logic [1:0] c, input logic h,
                         input logic r, input logic rs);
        cmd_valid = v; cmd = c; halt_det = h; dump_ready = r; rst = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n_en;
        int n_valid;
        int exp_addr;
        logic r;
        n_checks = 0; n_errors = 0;
        m_run = 0; m_step = 0; m_dump = 0; m_halt = 0;
        m_idx = 0; m_cnt = 0; m_cnt_s = 0;

        // Reset state, then RUN; HALT instruction retires in the 8th enabled cycle.
        cycle(0, 2'd0, 0, 0, 1);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_enable", 64'(enable), 64'd0);
        cycle(0, 2'd0, 0, 0, 0);
        cycle(1, 2'd0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 2'd0, 0, 0, 0);
        cycle(0, 2'd0, 1, 0, 0);
        cycle(0, 2'd0, 0, 0, 0);
        check("run_count", 64'(cycle_count), 64'd8);
        check("run_halted", 64'(halted), 64'd1);
        check("run_enable", 64'(enable), 64'd0);

        // Three STEPs with valid held high.
        cycle(0, 2'd0, 0, 0, 1);
        n_en = 0;
        for (int i = 0; i < 8; i++) begin
            if (enable) begin
                n_en++;
                check("step_ready", 64'(cmd_ready), 64'd0);
            end
            cycle(i < 6, 2'd1, 0, 0, 0);
        end
        check("step_enabled", 64'(n_en), 64'd3);
        check("step_count", 64'(cycle_count), 64'd3);

        // HALT command together with a retiring HALT instruction: DONE wins.
        cycle(0, 2'd0, 0, 0, 1);
        cycle(1, 2'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 2'd0, 0, 0, 0);
        cycle(1, 2'd2, 1, 0, 0);
        check("both_halted", 64'(halted), 64'd1);
        cycle(1, 2'd0, 0, 0, 0);
        cycle(1, 2'd0, 0, 0, 0);
        check("done_run_ignored", 64'(enable), 64'd0);

        // DUMP from DONE with ready toggling.
        cycle(1, 2'd3, 0, 0, 0);
        n_valid = 0; exp_addr = 0;
        for (int i = 0; i < 200; i++) begin
            if (!dump_valid) break;
            r = (i % 2 == 0);
            n_valid++;
            if (r) begin
                check("dump_order", 64'(dump_addr), 64'(exp_addr));
                exp_addr++;
            end
            cycle(0, 2'd0, 0, r, 0);
        end
        check("dump_valid_cycles", 64'(n_valid), 64'd63);
        check("dump_entries", 64'(exp_addr), 64'd32);
        check("dump_ret_done", 64'(halted), 64'd1);

        // Reset in the middle of a dump.
        cycle(0, 2'd0, 0, 0, 1);
        cycle(1, 2'd3, 0, 0, 0);
        for (int i = 0; i < 17; i++) cycle(0, 2'd0, 0, 1, 0);
        check("dump_at17", 64'(dump_addr), 64'd17);
        cycle(0, 2'd0, 0, 1, 1);
        check("rst_dump_addr", 64'(dump_addr), 64'd0);
        check("rst_dump_valid", 64'(dump_valid), 64'd0);
        check("rst_count", 64'(cycle_count), 64'd0);
        check("rst_ready2", 64'(cmd_ready), 64'd1);

        // Counter saturation on the narrow instance.
        cycle(1, 2'd0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 2'd0, 0, 0, 0);
        check("sat_count", 64'(s_cycle_count), 64'd7);
        check("wide_count", 64'(cycle_count), 64'd10);
        cycle(1, 2'd2, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
